clock_reset_sequencer: RTL and testbench
========================================

// Module: clock_reset_sequencer
// PURPOSE
//  Brings up the MMCM clock generator and owns the system reset. Pulses the MMCM
//  reset, waits for lock with timeout/retry, requires lock to stay stable, then
//  releases sys_rst_n. Relocks after lock loss; latches a fault after too many
//  failed attempts. Runs on the free-running 20 MHz input clock, ahead of the MMCM.
// PARAMETERS
//  RST_CYCLES    16    cycles mmcm_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT  2000  cycles to wait for lock per attempt (100 us @ 20 MHz)
//  STABLE_CYCLES 256   consecutive locked cycles required before release
//  MAX_RETRIES   3     failed attempts tolerated before S_FAULT
//  RETRY_W       $clog2(MAX_RETRIES+1)  derived width of retry_cnt
// PORTS
//  clk_20m      in   1        free-running 20 MHz clock
//  rst_n        in   1        asynchronous, active-low reset
//  mmcm_locked  in   1        MMCM LOCKED, asynchronous; 2-flop synchronised inside
//  soft_rst     in   1        sync 1-cycle request to restart the sequence
//  mmcm_rst     out  1        MMCM RST, active high
//  sys_rst_n    out  1        system reset, active low; downstream domains resync it
//  seq_state    out  3        current state encoding (see below)
//  retry_cnt    out  RETRY_W  timed-out attempts in current bring-up
//  fault        out  1        sticky: lock never achieved
//  loss_cnt     out  8        lock-loss events, saturating (CLKSEQ_LOSS_CNT_EN only)
// BEHAVIOUR
//  All outputs registered. rst_n low (async): state=S_RESET, mmcm_rst=1,
//  sys_rst_n=0, retry_cnt=0, fault=0, counters and sync flops 0.
//  locked_s = mmcm_locked after two flops (2-cycle latency).
//  States: S_RESET=0, S_WAIT_LOCK=1, S_STABLE=2, S_RUN=3, S_FAULT=4.
//  S_RESET: mmcm_rst=1, sys_rst_n=0; after RST_CYCLES cycles -> S_WAIT_LOCK,
//   mmcm_rst=0 on that edge. mmcm_rst is high exactly RST_CYCLES cycles/attempt.
//  S_WAIT_LOCK: timer counts from 0. locked_s=1 -> S_STABLE. Timer reaches
//   LOCK_TIMEOUT-1 without lock: retry_cnt==MAX_RETRIES -> S_FAULT, else
//   retry_cnt+1 and -> S_RESET. Lock wins if both occur on the same cycle.
//  S_STABLE: counter counts locked_s=1 cycles; reaching STABLE_CYCLES-1 ->
//   S_RUN, sys_rst_n=1 on that edge. locked_s=0 -> S_WAIT_LOCK, timer restarted,
//   retry_cnt unchanged.
//  S_RUN: sys_rst_n=1. locked_s=0 -> S_RESET, sys_rst_n=0 and mmcm_rst=1 on that
//   edge; retry_cnt cleared (new bring-up).
//  S_FAULT: mmcm_rst=1, sys_rst_n=0, fault=1; leaves only via rst_n or soft_rst.
//  soft_rst=1 in any state: highest priority -> S_RESET, retry_cnt=0, fault=0,
//   sys_rst_n=0, mmcm_rst=1 on the next edge; timers restart. Consecutive
//   soft_rst cycles keep restarting S_RESET.
//  Counters sized from parameters; none wrap (reset on every state entry).
// CONFIGURATION
//  CLKSEQ_LOSS_CNT_EN defined: loss_cnt increments on each S_RUN->S_RESET caused
//   by lock loss (not soft_rst), saturates at 255, cleared only by rst_n.
//  Undefined: loss_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//  clkseq_pkg: seq_state_t enum (values above), STATE_W=3 constant.
//  Sub-module sync_2ff (1-bit 2-flop synchroniser, async active-low reset to 0)
//  for mmcm_locked. FSM, timers and status outputs stay in this module.
// TESTING (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  Release rst_n, mmcm_locked=1 5 cycles after mmcm_rst falls -> mmcm_rst high
//   exactly 4 cycles; sys_rst_n rises on the 10th edge after the first edge
//   sampling mmcm_locked=1; seq_state 0->1->2->3.
//  mmcm_locked held 0 -> three 4-cycle mmcm_rst pulses 20 cycles apart,
//   retry_cnt 0->1->2, then fault=1, seq_state=4, mmcm_rst held 1.
//  In S_STABLE drop mmcm_locked for 1 cycle at count 5 -> back to S_WAIT_LOCK,
//   retry_cnt unchanged; sys_rst_n stays 0 until a full 8-cycle stable run.
//  In S_RUN drop mmcm_locked -> sys_rst_n=0, mmcm_rst=1 on 3rd edge after the
//   drop; with CLKSEQ_LOSS_CNT_EN loss_cnt 0->1; relock releases again.
//  soft_rst pulse in S_FAULT and mid-S_STABLE -> S_RESET next edge, fault=0,
//   retry_cnt=0; rst_n asserted mid-S_WAIT_LOCK -> all outputs at reset values
//   immediately, without a clock edge.

Source files
------------

// File: rtl/clkseq_pkg.sv
// Shared definitions for the clock/reset sequencer.
//   STATE_W      width of the sequencer state encoding
//   seq_state_t  sequencer states, encodings visible on seq_state
//   max3         helper used to size the shared phase timer
package clkseq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops clear to 0
//   d      asynchronous input
//   q      synchronised output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture; first stage may go metastable, second filters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Brings up the MMCM and owns the system reset. Pulses mmcm_rst, waits for
// lock with timeout and retry, requires lock to hold before releasing
// sys_rst_n, relocks after lock loss and latches a fault after too many
// failed attempts. Runs on the free-running 20 MHz input clock.
// Optional feature macro: CLKSEQ_LOSS_CNT_EN adds the loss_cnt output.
//   clk_20m      free-running input clock
//   rst_n        asynchronous active-low reset
//   mmcm_locked  MMCM LOCKED (asynchronous, synchronised internally)
//   soft_rst     one-cycle synchronous request to restart the sequence
//   mmcm_rst     MMCM reset, active high
//   sys_rst_n    system reset, active low
//   seq_state    current state encoding
//   retry_cnt    timed-out attempts in the current bring-up
//   fault        sticky: lock never achieved
//   loss_cnt     saturating count of lock-loss events (feature build only)
module clock_reset_sequencer
    import clkseq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 2000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int RETRY_W       = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk_20m,
    input  logic               rst_n,
    input  logic               mmcm_locked,
    input  logic               soft_rst,
    output logic               mmcm_rst,
    output logic               sys_rst_n,
    output logic [STATE_W-1:0] seq_state,
    output logic [RETRY_W-1:0] retry_cnt,
`ifdef CLKSEQ_LOSS_CNT_EN
    output logic               fault,
    output logic [7:0]         loss_cnt
`else
    output logic               fault
`endif
);

    // One timer is shared by all timed states; it restarts on every state entry.
    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic               locked_s;
    seq_state_t         state_r;
    seq_state_t         state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nx_s;
    logic               mmcm_rst_r;
    logic               mmcm_rst_nx_s;
    logic               sys_rst_n_r;
    logic               sys_rst_n_nx_s;
    logic               fault_r;
    logic               fault_nx_s;

    sync_2ff u_lock_sync (
        .clk   (clk_20m),
        .rst_n (rst_n),
        .d     (mmcm_locked),
        .q     (locked_s)
    );

    // State, timer, retry counter and registered outputs.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_RESET;
            cnt_r       <= {CNT_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            mmcm_rst_r  <= 1'b1;
            sys_rst_n_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            retry_r     <= retry_nx_s;
            mmcm_rst_r  <= mmcm_rst_nx_s;
            sys_rst_n_r <= sys_rst_n_nx_s;
            fault_r     <= fault_nx_s;
        end
    end

    // Next-state, timer and retry logic; soft_rst overrides everything.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = {CNT_W{1'b0}};
        retry_nx_s = retry_r;
        if (soft_rst) begin
            state_nx_s = S_RESET;
            retry_nx_s = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                S_RESET: begin
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        state_nx_s = S_WAIT_LOCK;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (locked_s) begin
                        state_nx_s = S_STABLE;
                    end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry_r == RETRY_W'(MAX_RETRIES)) begin
                            state_nx_s = S_FAULT;
                        end else begin
                            state_nx_s = S_RESET;
                            retry_nx_s = retry_r + RETRY_W'(1);
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_nx_s = S_WAIT_LOCK;
                    end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_nx_s = S_RUN;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Lock loss starts a fresh bring-up with a clean retry budget.
                    if (!locked_s) begin
                        state_nx_s = S_RESET;
                        retry_nx_s = {RETRY_W{1'b0}};
                    end else begin
                        state_nx_s = S_RUN;
                    end
                end
                S_FAULT: begin
                    state_nx_s = S_FAULT;
                end
                default: begin
                    state_nx_s = S_RESET;
                    retry_nx_s = {RETRY_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so outputs change on the entry edge.
    always_comb begin
        mmcm_rst_nx_s  = 1'b1;
        sys_rst_n_nx_s = 1'b0;
        fault_nx_s     = 1'b0;
        case (state_nx_s)
            S_RESET: begin
                mmcm_rst_nx_s = 1'b1;
            end
            S_WAIT_LOCK, S_STABLE: begin
                mmcm_rst_nx_s = 1'b0;
            end
            S_RUN: begin
                mmcm_rst_nx_s  = 1'b0;
                sys_rst_n_nx_s = 1'b1;
            end
            S_FAULT: begin
                mmcm_rst_nx_s = 1'b1;
                fault_nx_s    = 1'b1;
            end
            default: begin
                mmcm_rst_nx_s = 1'b1;
            end
        endcase
    end

`ifdef CLKSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_r;

    // Lock-loss event counter; soft_rst out of S_RUN is not a loss event.
    always_ff @(posedge clk_20m or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= 8'd0;
        end else if ((state_r == S_RUN) && !soft_rst && !locked_s &&
                     (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`endif

    assign mmcm_rst  = mmcm_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign seq_state = state_r;
    assign retry_cnt = retry_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench for clock_reset_sequencer (RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRIES=2). Stimulus pushes expected output changes
// tagged with the clock edge number; a monitor pops one entry per observed
// change of the output tuple and compares tuple and edge number.
module tb_clock_reset_sequencer;

    typedef struct packed {
        logic [2:0] st;
        logic       mr;
        logic       sn;
        logic [1:0] rc;
        logic       ft;
        logic [7:0] lc;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } ev_t;

    logic       clk_20m;
    logic       rst_n;
    logic       mmcm_locked;
    logic       soft_rst;
    logic       mmcm_rst;
    logic       sys_rst_n;
    logic [2:0] seq_state;
    logic [1:0] retry_cnt;
    logic       fault;
    logic [7:0] loss_obs;

    int   cyc;
    int   vectors;
    int   miscompares;
    int   loss_exp;
    logic mon_en;
    ev_t  exp_q[$];

`ifdef CLKSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
    assign loss_obs = loss_cnt;
`else
    assign loss_obs = 8'd0;
`endif

    clock_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_20m     (clk_20m),
        .rst_n       (rst_n),
        .mmcm_locked (mmcm_locked),
        .soft_rst    (soft_rst),
        .mmcm_rst    (mmcm_rst),
        .sys_rst_n   (sys_rst_n),
        .seq_state   (seq_state),
        .retry_cnt   (retry_cnt),
`ifdef CLKSEQ_LOSS_CNT_EN
        .fault       (fault),
        .loss_cnt    (loss_cnt)
`else
        .fault       (fault)
`endif
    );

    initial clk_20m = 1'b0;
    always #25 clk_20m = ~clk_20m;

    // Edge counter: value N is visible between posedge N and posedge N+1.
    always @(posedge clk_20m) cyc <= cyc + 1;

    function automatic out_t cur_out();
        out_t o;
        o.st = seq_state;
        o.mr = mmcm_rst;
        o.sn = sys_rst_n;
        o.rc = retry_cnt;
        o.ft = fault;
        o.lc = loss_obs;
        return o;
    endfunction

    function automatic out_t mk(input int st, input int mr, input int sn,
                                input int rc, input int ft, input int lc);
        out_t o;
        o.st = st[2:0];
        o.mr = mr[0];
        o.sn = sn[0];
        o.rc = rc[1:0];
        o.ft = ft[0];
        o.lc = lc[7:0];
        return o;
    endfunction

    task automatic expect_ev(input int c, input int st, input int mr,
                             input int sn, input int rc, input int ft);
        ev_t e;
        e.cyc = c;
        e.o   = mk(st, mr, sn, rc, ft, loss_exp);
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input out_t exp_o);
        out_t a;
        a = cur_out();
        vectors++;
        if (a !== exp_o) begin
            miscompares++;
            $display("FAIL %s: got st=%0d mr=%0b sn=%0b rc=%0d ft=%0b lc=%0d, want st=%0d mr=%0b sn=%0b rc=%0d ft=%0b lc=%0d",
                     name, a.st, a.mr, a.sn, a.rc, a.ft, a.lc,
                     exp_o.st, exp_o.mr, exp_o.sn, exp_o.rc, exp_o.ft, exp_o.lc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk_20m);
    endtask

    // Monitor: every change of the output tuple consumes one expected entry.
    initial begin : monitor
        out_t prev;
        out_t a;
        ev_t  e;
        prev = '0;
        forever begin
            @(negedge clk_20m);
            a = cur_out();
            if (!mon_en) begin
                prev = a;
            end else if (a !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change @edge %0d: got st=%0d mr=%0b sn=%0b rc=%0d ft=%0b lc=%0d, want no change",
                             cyc, a.st, a.mr, a.sn, a.rc, a.ft, a.lc);
                end else begin
                    e = exp_q.pop_front();
                    if ((a !== e.o) || (cyc != e.cyc)) begin
                        miscompares++;
                        $display("FAIL sequence @edge %0d: got st=%0d mr=%0b sn=%0b rc=%0d ft=%0b lc=%0d, want @edge %0d st=%0d mr=%0b sn=%0b rc=%0d ft=%0b lc=%0d",
                                 cyc, a.st, a.mr, a.sn, a.rc, a.ft, a.lc,
                                 e.cyc, e.o.st, e.o.mr, e.o.sn, e.o.rc, e.o.ft, e.o.lc);
                    end
                end
                prev = a;
            end
        end
    end

    initial begin : stimulus
        int f;
        int d;
        int s;
        int r;
        int t;
        ev_t e;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        loss_exp    = 0;
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        mmcm_locked = 1'b0;
        soft_rst    = 1'b0;

        repeat (3) @(negedge clk_20m);
        check_now("reset_state", mk(0, 1, 0, 0, 0, 0));

        // Bring-up: lock appears 5 cycles after mmcm_rst falls.
        rst_n  = 1'b1;
        mon_en = 1'b1;
        f = cyc + 4;
        expect_ev(f, 1, 0, 0, 0, 0);
        goto(f + 5);
        mmcm_locked = 1'b1;
        expect_ev(f + 8, 2, 0, 0, 0, 0);
        expect_ev(f + 16, 3, 0, 1, 0, 0);

        // Lock loss in S_RUN, then relock.
        goto(f + 19);
        d = cyc;
        mmcm_locked = 1'b0;
`ifdef CLKSEQ_LOSS_CNT_EN
        loss_exp = 1;
`endif
        expect_ev(d + 3, 0, 1, 0, 0, 0);
        goto(d + 3);
        mmcm_locked = 1'b1;
        expect_ev(d + 7, 1, 0, 0, 0, 0);
        expect_ev(d + 8, 2, 0, 0, 0, 0);
        expect_ev(d + 16, 3, 0, 1, 0, 0);

        // soft_rst from S_RUN, then a one-cycle lock glitch at stable count 5.
        goto(d + 18);
        soft_rst = 1'b1;
        s = cyc + 1;
        expect_ev(s, 0, 1, 0, 0, 0);
        @(negedge clk_20m);
        soft_rst = 1'b0;
        expect_ev(s + 4, 1, 0, 0, 0, 0);
        expect_ev(s + 5, 2, 0, 0, 0, 0);
        goto(s + 8);
        mmcm_locked = 1'b0;
        @(negedge clk_20m);
        mmcm_locked = 1'b1;
        expect_ev(s + 11, 1, 0, 0, 0, 0);
        expect_ev(s + 12, 2, 0, 0, 0, 0);
        expect_ev(s + 20, 3, 0, 1, 0, 0);

        // soft_rst from S_RUN again, then soft_rst mid-S_STABLE.
        goto(s + 21);
        soft_rst = 1'b1;
        r = cyc + 1;
        expect_ev(r, 0, 1, 0, 0, 0);
        @(negedge clk_20m);
        soft_rst = 1'b0;
        expect_ev(r + 4, 1, 0, 0, 0, 0);
        expect_ev(r + 5, 2, 0, 0, 0, 0);
        goto(r + 7);
        soft_rst = 1'b1;
        t = cyc + 1;
        expect_ev(t, 0, 1, 0, 0, 0);
        @(negedge clk_20m);
        soft_rst = 1'b0;

        // Lock never comes: two retries then fault.
        mmcm_locked = 1'b0;
        expect_ev(t + 4, 1, 0, 0, 0, 0);
        expect_ev(t + 24, 0, 1, 0, 1, 0);
        expect_ev(t + 28, 1, 0, 0, 1, 0);
        expect_ev(t + 48, 0, 1, 0, 2, 0);
        expect_ev(t + 52, 1, 0, 0, 2, 0);
        expect_ev(t + 72, 4, 1, 0, 2, 1);

        // soft_rst leaves S_FAULT.
        goto(t + 75);
        soft_rst = 1'b1;
        expect_ev(t + 76, 0, 1, 0, 0, 0);
        @(negedge clk_20m);
        soft_rst = 1'b0;
        expect_ev(t + 80, 1, 0, 0, 0, 0);

        // Asynchronous reset mid-S_WAIT_LOCK takes effect without a clock edge.
        goto(t + 85);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_now("async_reset", mk(0, 1, 0, 0, 0, 0));
        @(negedge clk_20m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_20m);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_change: got nothing, want @edge %0d st=%0d mr=%0b sn=%0b rc=%0d ft=%0b",
                     e.cyc, e.o.st, e.o.mr, e.o.sn, e.o.rc, e.o.ft);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
